// File: rtl/rvx_bus_arbiter.sv
// Two-master (ibus read-only, dbus read/write) arbiter onto one single-port
// target. Latches request pulses per master, grants round-robin, forwards
// completions to the owner and aborts stalled transactions after a timeout.
// Ports: clock/reset; ibus_* (address, rrequest, rdata, rresponse);
//   dbus_* (address, r/wrequest, wdata, wstrobe, rdata, r/wresponse);
//   target_* (address, r/wrequest, wdata, wstrobe, rdata, r/wresponse);
//   timeout_error (one-cycle abort pulse).
module rvx_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] ibus_address,
   input  logic        ibus_rrequest,
   output logic [31:0] ibus_rdata,
   output logic        ibus_rresponse,
   input  logic [31:0] dbus_address,
   input  logic        dbus_rrequest,
   input  logic        dbus_wrequest,
   input  logic [31:0] dbus_wdata,
   input  logic [3:0]  dbus_wstrobe,
   output logic [31:0] dbus_rdata,
   output logic        dbus_rresponse,
   output logic        dbus_wresponse,
   output logic [31:0] target_address,
   output logic        target_rrequest,
   output logic        target_wrequest,
   output logic [31:0] target_wdata,
   output logic [3:0]  target_wstrobe,
   input  logic [31:0] target_rdata,
   input  logic        target_rresponse,
   input  logic        target_wresponse,
   output logic        timeout_error
);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;
   localparam int   CW    = (TIMEOUT_CYCLES > 1) ?
                            $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   state_t        state, state_nx;
   logic          owner, owner_nx;
   logic          last_grant;
   logic          i_vld;
   logic [31:0]   i_addr;
   logic          d_vld, d_write;
   logic [31:0]   d_addr, d_wdata;
   logic [3:0]    d_wstrb;
   logic [31:0]   i_rdata_q, d_rdata_q;
   logic [CW-1:0] tcnt;

   logic        own_write, resp_hit, tmo, done;
   logic        i_clear, d_clear;
   logic [31:0] fwd_data;

   assign own_write = (owner == OWN_D) && d_write;
   assign resp_hit  = own_write ? target_wresponse : target_rresponse;
   // A real response in the timeout cycle wins over the abort.
   assign tmo       = (state == BUSY) && (TIMEOUT_CYCLES != 0) &&
                      (tcnt == TMAX) && !resp_hit;
   assign done      = (state == BUSY) && (resp_hit || tmo);
   assign fwd_data  = resp_hit ? target_rdata : 32'h0;
   assign i_clear   = done && (owner == OWN_I);
   assign d_clear   = done && (owner == OWN_D);

   always_comb begin
      state_nx        = state;
      owner_nx        = owner;
      ibus_rdata      = i_rdata_q;
      dbus_rdata      = d_rdata_q;
      ibus_rresponse  = 1'b0;
      dbus_rresponse  = 1'b0;
      dbus_wresponse  = 1'b0;
      target_rrequest = 1'b0;
      target_wrequest = 1'b0;
      target_address  = 32'h0;
      target_wdata    = 32'h0;
      target_wstrobe  = 4'h0;
      timeout_error   = 1'b0;
      if (state != IDLE) begin
         if (owner == OWN_I) begin
            target_address = i_addr;
         end else begin
            target_address = d_addr;
            if (d_write) begin
               target_wdata   = d_wdata;
               target_wstrobe = d_wstrb;
            end
         end
      end
      unique case (state)
         IDLE: begin
            if (i_vld || d_vld) begin
               state_nx = GRANT;
               if (i_vld && d_vld)
                  owner_nx = ~last_grant;
               else
                  owner_nx = d_vld ? OWN_D : OWN_I;
            end
         end
         GRANT: begin
            target_rrequest = !own_write;
            target_wrequest = own_write;
            state_nx        = BUSY;
         end
         BUSY: begin
            if (done) begin
               state_nx      = IDLE;
               timeout_error = tmo;
               if (owner == OWN_I) begin
                  ibus_rresponse = 1'b1;
                  ibus_rdata     = fwd_data;
               end else if (d_write) begin
                  dbus_wresponse = 1'b1;
               end else begin
                  dbus_rresponse = 1'b1;
                  dbus_rdata     = fwd_data;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= OWN_I;
         last_grant <= OWN_D;
         tcnt       <= '0;
         i_rdata_q  <= 32'h0;
         d_rdata_q  <= 32'h0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         if (state == IDLE && state_nx == GRANT)
            last_grant <= owner_nx;
         if (state == GRANT)
            tcnt <= '0;
         else if (state == BUSY && !done)
            tcnt <= tcnt + 1'b1;
         if (i_clear)
            i_rdata_q <= fwd_data;
         if (d_clear && !d_write)
            d_rdata_q <= fwd_data;
      end
   end

   // Slots: a slot freed on this edge can take a new request on the same edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         i_vld   <= 1'b0;
         i_addr  <= 32'h0;
         d_vld   <= 1'b0;
         d_write <= 1'b0;
         d_addr  <= 32'h0;
         d_wdata <= 32'h0;
         d_wstrb <= 4'h0;
      end else begin
         if (ibus_rrequest && (!i_vld || i_clear)) begin
            i_vld  <= 1'b1;
            i_addr <= ibus_address;
         end else if (i_clear) begin
            i_vld <= 1'b0;
         end
         if ((dbus_rrequest || dbus_wrequest) && (!d_vld || d_clear)) begin
            d_vld   <= 1'b1;
            d_write <= dbus_wrequest;
            d_addr  <= dbus_address;
            d_wdata <= dbus_wdata;
            d_wstrb <= dbus_wstrobe;
         end else if (d_clear) begin
            d_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Self-checking bench for rvx_bus_arbiter: table of single transactions
// plus hand-written sequences; a target model and response scoreboard.
module tb_rvx_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ibus_address = '0;
   logic        ibus_rrequest = 1'b0;
   logic [31:0] ibus_rdata;
   logic        ibus_rresponse;
   logic [31:0] dbus_address = '0;
   logic        dbus_rrequest = 1'b0;
   logic        dbus_wrequest = 1'b0;
   logic [31:0] dbus_wdata = '0;
   logic [3:0]  dbus_wstrobe = '0;
   logic [31:0] dbus_rdata;
   logic        dbus_rresponse;
   logic        dbus_wresponse;
   logic [31:0] target_address;
   logic        target_rrequest;
   logic        target_wrequest;
   logic [31:0] target_wdata;
   logic [3:0]  target_wstrobe;
   logic [31:0] target_rdata = '0;
   logic        target_rresponse = 1'b0;
   logic        target_wresponse = 1'b0;
   logic        timeout_error;

   rvx_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .ibus_address(ibus_address), .ibus_rrequest(ibus_rrequest),
      .ibus_rdata(ibus_rdata), .ibus_rresponse(ibus_rresponse),
      .dbus_address(dbus_address), .dbus_rrequest(dbus_rrequest),
      .dbus_wrequest(dbus_wrequest), .dbus_wdata(dbus_wdata),
      .dbus_wstrobe(dbus_wstrobe), .dbus_rdata(dbus_rdata),
      .dbus_rresponse(dbus_rresponse), .dbus_wresponse(dbus_wresponse),
      .target_address(target_address), .target_rrequest(target_rrequest),
      .target_wrequest(target_wrequest), .target_wdata(target_wdata),
      .target_wstrobe(target_wstrobe), .target_rdata(target_rdata),
      .target_rresponse(target_rresponse),
      .target_wresponse(target_wresponse),
      .timeout_error(timeout_error)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
      logic        terr;
   } exp_t;

   typedef struct {
      bit          dbus;
      bit          w;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
   } vec_t;

   exp_t q_t[$], q_i[$], q_d[$];
   int n_chk = 0, n_pass = 0;
   int n_treq = 0, n_iresp = 0, n_dresp = 0, n_terr = 0;
   int treq_cyc = 0, i_resp_cyc = 0, d_resp_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Target model: small byte-addressable memory, answers one cycle after
   // a request unless silenced; inject forces a stray read response.
   logic [31:0] mem [64];
   bit          pend_r = 0, pend_w = 0, silent = 0, inject = 0;
   logic [31:0] pend_data = '0;
   logic [5:0]  idx;
   exp_t        e;

   always @(posedge clock) begin
      #1;
      target_rresponse = 1'b0;
      target_wresponse = 1'b0;
      if (pend_r && !silent) begin
         target_rresponse = 1'b1;
         target_rdata     = pend_data;
      end
      if (pend_w && !silent) target_wresponse = 1'b1;
      if (inject) begin
         target_rresponse = 1'b1;
         target_rdata     = 32'hDEADBEEF;
      end
      pend_r = 0;
      pend_w = 0;
   end

   always @(negedge clock) begin
      if (target_rrequest || target_wrequest) begin
         treq_cyc = cyc;
         n_treq++;
         chk("target req expected", 32'(q_t.size() > 0), 1);
         chk("target req one kind",
             32'(target_rrequest && target_wrequest), 0);
         if (q_t.size() > 0) begin
            e = q_t.pop_front();
            chk("target kind", 32'(target_wrequest), 32'(e.w));
            chk("target addr", target_address, e.addr);
            chk("target wdata", target_wdata, e.wdata);
            chk("target wstrobe", 32'(target_wstrobe), 32'(e.strb));
         end
         idx = target_address[7:2];
         if (target_wrequest) begin
            for (int b = 0; b < 4; b++)
               if (target_wstrobe[b])
                  mem[idx][8*b +: 8] = target_wdata[8*b +: 8];
            pend_w = 1;
         end else begin
            pend_data = mem[idx];
            pend_r    = 1;
         end
      end
      if (ibus_rresponse) begin
         i_resp_cyc = cyc;
         n_iresp++;
         chk("ibus resp expected", 32'(q_i.size() > 0), 1);
         if (q_i.size() > 0) begin
            e = q_i.pop_front();
            chk("ibus rdata", ibus_rdata, e.rdata);
            chk("ibus terr", 32'(timeout_error), 32'(e.terr));
         end
      end
      if (dbus_rresponse || dbus_wresponse) begin
         d_resp_cyc = cyc;
         n_dresp++;
         chk("dbus resp expected", 32'(q_d.size() > 0), 1);
         if (q_d.size() > 0) begin
            e = q_d.pop_front();
            chk("dbus resp kind", 32'(dbus_wresponse), 32'(e.w));
            if (!e.w) chk("dbus rdata", dbus_rdata, e.rdata);
            chk("dbus terr", 32'(timeout_error), 32'(e.terr));
         end
      end
      if (timeout_error) n_terr++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] wd,
                        input logic [3:0] ws, output int rc);
      tick();
      ibus_rrequest = ir;
      ibus_address  = ia;
      dbus_rrequest = dr;
      dbus_wrequest = dw;
      dbus_address  = da;
      dbus_wdata    = wd;
      dbus_wstrobe  = ws;
      rc = cyc;
      tick();
      ibus_rrequest = 0;
      dbus_rrequest = 0;
      dbus_wrequest = 0;
   endtask

   task automatic drain(input string nm, input int bound);
      int k = 0;
      while ((q_t.size() + q_i.size() + q_d.size()) > 0 && k < bound) begin
         tick();
         k++;
      end
      chk(nm, 32'(q_t.size() + q_i.size() + q_d.size()), 0);
   endtask

   task automatic do_reset();
      tick();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " ctl"}, 32'({ibus_rresponse, dbus_rresponse, dbus_wresponse,
          target_rrequest, target_wrequest, timeout_error, target_wstrobe}), 0);
      chk({nm, " taddr"}, target_address, 0);
      chk({nm, " twdata"}, target_wdata, 0);
      chk({nm, " ibus_rdata"}, ibus_rdata, 0);
      chk({nm, " dbus_rdata"}, dbus_rdata, 0);
   endtask

   function automatic exp_t mk(input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] s,
                               input logic [31:0] rd, input logic te);
      exp_t x;
      x.w = w; x.addr = a; x.wdata = wd; x.strb = s;
      x.rdata = rd; x.terr = te;
      return x;
   endfunction

   vec_t vt[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int rc, ni, nd, t0, r0, i0, d0;
      for (int k = 0; k < 64; k++) mem[k] = 32'hCAFEF00D;

      vt[0] = '{0, 0, 32'h100,  32'h0,        4'h0, 32'hCAFEF00D};
      vt[1] = '{1, 1, 32'h1004, 32'h11223344, 4'hF, 32'h0};
      vt[2] = '{1, 0, 32'h1004, 32'h0,        4'h0, 32'h11223344};
      vt[3] = '{1, 1, 32'h1004, 32'hAABBCCDD, 4'h5, 32'h0};
      vt[4] = '{0, 0, 32'h4,    32'h0,        4'h0, 32'h11BB33DD};
      vt[5] = '{1, 0, 32'h8,    32'h0,        4'h0, 32'hCAFEF00D};
      vt[6] = '{1, 1, 32'h8,    32'h0,        4'h8, 32'h0};
      vt[7] = '{0, 0, 32'h208,  32'h0,        4'h0, 32'h00FEF00D};

      tick();
      tick();
      chk_zero("reset");
      reset = 0;

      for (int i = 0; i < 8; i++) begin
         q_t.push_back(mk(vt[i].w, vt[i].addr, vt[i].w ? vt[i].wdata : 0,
                          vt[i].w ? vt[i].strb : 4'h0, 0, 0));
         if (vt[i].dbus)
            q_d.push_back(mk(vt[i].w, vt[i].addr, 0, 0, vt[i].rdata, 0));
         else
            q_i.push_back(mk(0, vt[i].addr, 0, 0, vt[i].rdata, 0));
         drive(!vt[i].dbus, vt[i].addr, vt[i].dbus && !vt[i].w,
               vt[i].dbus && vt[i].w, vt[i].addr, vt[i].wdata,
               vt[i].strb, rc);
         drain($sformatf("row%0d drained", i), 20);
         chk($sformatf("row%0d treq latency", i), treq_cyc - rc, 2);
         chk($sformatf("row%0d resp latency", i),
             (vt[i].dbus ? d_resp_cyc : i_resp_cyc) - rc, 3);
         if (!vt[i].w)
            chk($sformatf("row%0d rdata held", i),
                vt[i].dbus ? dbus_rdata : ibus_rdata, vt[i].rdata);
         if (i == 0) chk("row0 dbus_rdata untouched", dbus_rdata, 0);
      end

      // Simultaneous ibus read and dbus write after reset: ibus first.
      do_reset();
      i0 = n_iresp; d0 = n_dresp;
      q_t.push_back(mk(0, 32'h200, 0, 0, 0, 0));
      q_t.push_back(mk(1, 32'h1000, 32'h1, 4'hF, 0, 0));
      q_i.push_back(mk(0, 32'h200, 0, 0, 32'hCAFEF00D, 0));
      q_d.push_back(mk(1, 32'h1000, 0, 0, 0, 0));
      drive(1, 32'h200, 0, 1, 32'h1000, 32'h1, 4'hF, rc);
      drain("simul drained", 30);
      chk("simul ibus resp count", n_iresp - i0, 1);
      chk("simul dbus resp count", n_dresp - d0, 1);

      // Both masters re-request in every response cycle: strict alternation.
      do_reset();
      for (int n = 0; n < 10; n++) begin
         q_t.push_back(mk(0, 32'h420 + 4 * n, 0, 0, 0, 0));
         q_t.push_back(mk(0, 32'h860 + 4 * n, 0, 0, 0, 0));
      end
      tick();
      ibus_address = 32'h420; ibus_rrequest = 1;
      dbus_address = 32'h860; dbus_rrequest = 1;
      q_i.push_back(mk(0, 0, 0, 0, 32'hCAFEF00D, 0));
      q_d.push_back(mk(0, 0, 0, 0, 32'hCAFEF00D, 0));
      ni = 1; nd = 1;
      for (int k = 0; k < 300 && (q_i.size() + q_d.size()) > 0; k++) begin
         tick();
         ibus_rrequest = 0;
         dbus_rrequest = 0;
         #1;
         if (ibus_rresponse && ni < 10) begin
            ibus_address = 32'h420 + 4 * ni; ibus_rrequest = 1; ni++;
            q_i.push_back(mk(0, 0, 0, 0, 32'hCAFEF00D, 0));
         end
         if (dbus_rresponse && nd < 10) begin
            dbus_address = 32'h860 + 4 * nd; dbus_rrequest = 1; nd++;
            q_d.push_back(mk(0, 0, 0, 0, 32'hCAFEF00D, 0));
         end
      end
      tick();
      ibus_rrequest = 0;
      dbus_rrequest = 0;
      drain("fair drained", 20);
      chk("fair ibus issued", ni, 10);
      chk("fair dbus issued", nd, 10);

      // Target never answers a dbus read: abort after 8 idle BUSY cycles.
      silent = 1;
      t0 = n_terr;
      q_t.push_back(mk(0, 32'h40, 0, 0, 0, 0));
      q_d.push_back(mk(0, 32'h40, 0, 0, 32'h0, 1));
      drive(0, 0, 1, 0, 32'h40, 0, 0, rc);
      drain("timeout drained", 40);
      chk("timeout latency", d_resp_cyc - rc, 11);
      chk("timeout held rdata", dbus_rdata, 0);
      chk("timeout pulses", n_terr - t0, 1);
      silent = 0;
      d0 = n_dresp;
      @(negedge clock);
      @(negedge clock);
      inject = 1;
      @(negedge clock);
      inject = 0;
      repeat (4) tick();
      chk("late resp ignored", n_dresp - d0, 0);
      chk("late resp no error", n_terr - t0, 1);
      chk("late resp rdata", dbus_rdata, 0);

      // Read+write together, and a second ibus request into a full slot.
      do_reset();
      r0 = n_treq; i0 = n_iresp;
      q_t.push_back(mk(0, 32'h300, 0, 0, 0, 0));
      q_t.push_back(mk(1, 32'h1010, 32'h5, 4'h3, 0, 0));
      q_i.push_back(mk(0, 32'h300, 0, 0, 32'h00000001, 0));
      q_d.push_back(mk(1, 32'h1010, 0, 0, 0, 0));
      tick();
      ibus_address = 32'h300; ibus_rrequest = 1;
      dbus_address = 32'h1010; dbus_wdata = 32'h5; dbus_wstrobe = 4'h3;
      dbus_rrequest = 1; dbus_wrequest = 1;
      tick();
      dbus_rrequest = 0; dbus_wrequest = 0;
      ibus_address = 32'h304;
      tick();
      ibus_rrequest = 0;
      drain("dual drained", 30);
      repeat (10) tick();
      chk("dual target reqs", n_treq - r0, 2);
      chk("dual ibus resps", n_iresp - i0, 1);

      // Reset in BUSY on a dbus write abandons it silently.
      silent = 1;
      d0 = n_dresp;
      q_t.push_back(mk(1, 32'h1020, 32'h77, 4'hF, 0, 0));
      drive(0, 0, 0, 1, 32'h1020, 32'h77, 4'hF, rc);
      tick();
      tick();
      chk("busy taddr", target_address, 32'h1020);
      reset = 1;
      #1;
      chk_zero("async reset");
      tick();
      tick();
      reset = 0;
      silent = 0;
      q_t.push_back(mk(0, 32'h3C, 0, 0, 0, 0));
      q_i.push_back(mk(0, 32'h3C, 0, 0, 32'hCAFEF00D, 0));
      drive(1, 32'h3C, 0, 0, 0, 0, 0, rc);
      drain("post reset drained", 20);
      chk("post reset latency", i_resp_cyc - rc, 3);
      chk("post reset rdata", ibus_rdata, 32'hCAFEF00D);
      chk("no abandoned wresp", n_dresp - d0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
